// File: rtl/half_pwm_pkg.sv
// Shared types and constants for the half-bridge PWM burst sequencer and
// the half_pwm_die generator it drives.
package half_pwm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FIRE       = 3'd1,
      ST_WAIT_PULSE = 3'd2,
      ST_GAP        = 3'd3,
      ST_FINISH     = 3'd4,
      ST_ABORT      = 3'd5
   } state_e;

   // Cycles the generator is held disabled after an abort or watchdog expiry.
   localparam int ABORT_HOLD = 2;

   // Default field widths, matching half_pwm_die.
   localparam int RAM_WIDTH_DEF = 32;
   localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/pwm_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module pwm_watchdog #(
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   // The counter reads 0 in the first enabled cycle, so expiry is one count early.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

   logic [WD_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != WD_LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = enable_i && !clear_i && (cnt_q == WD_LAST);

endmodule

// File: rtl/half_pwm_burst_ctrl.sv
// Burst sequencer for half_pwm_die: shadows a burst command, strobes the
// generator once per pulse, counts completions, and handles abort/watchdog.
module half_pwm_burst_ctrl
   import half_pwm_pkg::*;
#(
   parameter int _RAM_WIDTH     = RAM_WIDTH_DEF,
   parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                  io_clk,
   input  logic                  io_rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CNT_WIDTH-1:0]  cmd_pulse_cnt,
   input  logic [_RAM_WIDTH-1:0] cmd_die_period,
   input  logic [_RAM_WIDTH-1:0] cmd_pulse_period,
   input  logic [_RAM_WIDTH-1:0] cmd_gap,
   input  logic                  cmd_default_level,
   input  logic                  abort,
   output logic                  pwm_en,
   output logic                  pwm_dis,
   output logic [_RAM_WIDTH-1:0] die_period,
   output logic [_RAM_WIDTH-1:0] pulse_period,
   output logic                  default_level,
   input  logic                  pulse_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  timeout,
   output logic [CNT_WIDTH-1:0]  pulses_done
);

   localparam int HOLD_W = $clog2(ABORT_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ABORT_HOLD - 1);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  pulses_q, pulses_d, pulses_inc;
   logic [_RAM_WIDTH-1:0] die_q, die_d;
   logic [_RAM_WIDTH-1:0] width_q, width_d;
   logic [_RAM_WIDTH-1:0] gap_q, gap_d;
   logic [_RAM_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic                  level_q, level_d;
   logic                  timeout_q, timeout_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;

   logic accept;
   logic last_pulse;
   logic gap_done;
   logic hold_last;
   logic wd_clear;
   logic wd_enable;
   logic wd_expire;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign accept     = (state_q == ST_IDLE) && cmd_valid;
   assign pulses_inc = sat_inc(pulses_q);
   assign last_pulse = (pulses_inc == cnt_q);
   assign gap_done   = (gap_cnt_q == '0);
   assign hold_last  = (hold_q == HOLD_LAST);
   assign wd_clear   = (state_q == ST_FIRE);
   assign wd_enable  = (state_q == ST_WAIT_PULSE);

   pwm_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i   (io_clk),
      .rst_ni  (io_rst_n),
      .clear_i (wd_clear),
      .enable_i(wd_enable),
      .expire_o(wd_expire)
   );

   always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Abort outranks everything, including a pulse that would end the burst.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = (cmd_pulse_cnt == '0) ? ST_FINISH : ST_FIRE;
            end
         end
         ST_FIRE: begin
            state_d = abort ? ST_ABORT : ST_WAIT_PULSE;
         end
         ST_WAIT_PULSE: begin
            if (abort) begin
               state_d = ST_ABORT;
            end else if (pulse_valid) begin
               if (last_pulse) begin
                  state_d = ST_FINISH;
               end else if (gap_q == '0) begin
                  state_d = ST_FIRE;
               end else begin
                  state_d = ST_GAP;
               end
            end else if (wd_expire) begin
               state_d = ST_ABORT;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_ABORT;
            end else if (gap_done) begin
               state_d = ST_FIRE;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         ST_ABORT: begin
            if (hold_last) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      die_d     = die_q;
      width_d   = width_q;
      gap_d     = gap_q;
      level_d   = level_q;
      pulses_d  = pulses_q;
      gap_cnt_d = gap_cnt_q;
      timeout_d = timeout_q;
      hold_d    = '0;
      if (accept) begin
         cnt_d     = cmd_pulse_cnt;
         die_d     = cmd_die_period;
         width_d   = cmd_pulse_period;
         gap_d     = cmd_gap;
         level_d   = cmd_default_level;
         pulses_d  = '0;
         timeout_d = 1'b0;
      end
      case (state_q)
         ST_WAIT_PULSE: begin
            if (pulse_valid) begin
               pulses_d = pulses_inc;
               if (gap_q != '0) begin
                  gap_cnt_d = gap_q - 1'b1;
               end
            end else if (wd_expire) begin
               timeout_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (!gap_done) begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         ST_ABORT: begin
            hold_d = hold_q + 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
         cnt_q     <= '0;
         die_q     <= '0;
         width_q   <= '0;
         gap_q     <= '0;
         level_q   <= 1'b0;
         pulses_q  <= '0;
         gap_cnt_q <= '0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         die_q     <= die_d;
         width_q   <= width_d;
         gap_q     <= gap_d;
         level_q   <= level_d;
         pulses_q  <= pulses_d;
         gap_cnt_q <= gap_cnt_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
      end
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      pwm_en    = 1'b0;
      pwm_dis   = 1'b0;
      done      = 1'b0;
      aborted   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_FIRE: begin
            pwm_en = 1'b1;
         end
         ST_FINISH: begin
            done = 1'b1;
         end
         ST_ABORT: begin
            pwm_dis = 1'b1;
            aborted = hold_last;
         end
         default: begin
         end
      endcase
   end

   assign die_period    = die_q;
   assign pulse_period  = width_q;
   assign default_level = level_q;
   assign timeout       = timeout_q;
   assign pulses_done   = pulses_q;

endmodule

// File: tb/tb_half_pwm_burst_ctrl.sv
// Bench for half_pwm_burst_ctrl with a behavioural half_pwm_die model
// (die = 3, pulse = 5) and a burst-result scoreboard.
module tb_half_pwm_burst_ctrl;

   localparam int RW  = 32;
   localparam int CW  = 16;
   localparam int TO  = 16;
   localparam int DIE = 3;
   localparam int PW  = 5;

   typedef struct {
      int   cnt;
      int   gap;
      int   abort_at;
      int   exp_pulses;
      int   exp_en;
      int   exp_done;
      int   exp_ab;
      logic lvl;
   } vec_t;

   logic          io_clk = 1'b0;
   logic          io_rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CW-1:0] cmd_pulse_cnt = '0;
   logic [RW-1:0] cmd_die_period = '0;
   logic [RW-1:0] cmd_pulse_period = '0;
   logic [RW-1:0] cmd_gap = '0;
   logic          cmd_default_level = 1'b0;
   logic          abort = 1'b0;
   logic          pwm_en;
   logic          pwm_dis;
   logic [RW-1:0] die_period;
   logic [RW-1:0] pulse_period;
   logic          default_level;
   logic          pulse_valid = 1'b0;
   logic          busy;
   logic          done;
   logic          aborted;
   logic          timeout;
   logic [CW-1:0] pulses_done;

   always #5 io_clk = ~io_clk;

   half_pwm_burst_ctrl #(
      ._RAM_WIDTH    (RW),
      .CNT_WIDTH     (CW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .io_clk           (io_clk),
      .io_rst_n         (io_rst_n),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_pulse_cnt    (cmd_pulse_cnt),
      .cmd_die_period   (cmd_die_period),
      .cmd_pulse_period (cmd_pulse_period),
      .cmd_gap          (cmd_gap),
      .cmd_default_level(cmd_default_level),
      .abort            (abort),
      .pwm_en           (pwm_en),
      .pwm_dis          (pwm_dis),
      .die_period       (die_period),
      .pulse_period     (pulse_period),
      .default_level    (default_level),
      .pulse_valid      (pulse_valid),
      .busy             (busy),
      .done             (done),
      .aborted          (aborted),
      .timeout          (timeout),
      .pulses_done      (pulses_done)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   vec_t exp_q[$];
   vec_t cur;
   int   m_cnt = 0;
   int   pv_cyc = 0;
   bit   mute = 1'b0;
   int   burst_en = 0;
   int   acc_cyc = 0;
   int   acc_cnt = 0;
   int   en_cyc = 0;
   int   ab_cyc = 0;
   int   dis_start_cyc = 0;
   int   dis_run = 0;
   int   shadow_bad = 0;
   int   en_total = 0;
   int   done_total = 0;
   int   ab_total = 0;
   bit   end_seen = 1'b0;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   initial begin
      forever begin
         @(posedge io_clk);
         cyc++;
      end
   end

   // half_pwm_die stand-in: one pulse_valid DIE+PW cycles after each start strobe.
   initial begin
      forever begin
         @(negedge io_clk);
         if (pwm_dis || !io_rst_n) begin
            m_cnt       = 0;
            pulse_valid = 1'b0;
         end else if (pwm_en && !mute) begin
            m_cnt       = DIE + PW;
            pulse_valid = 1'b0;
         end else if (m_cnt != 0) begin
            m_cnt--;
            pulse_valid = (m_cnt == 0);
            if (m_cnt == 0) pv_cyc = cyc;
         end else begin
            pulse_valid = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge io_clk);
         if (!io_rst_n) begin
            burst_en = 0;
            dis_run  = 0;
         end else begin
            dis_run = pwm_dis ? dis_run + 1 : 0;
            if (pwm_dis && dis_run == 1) dis_start_cyc = cyc;
            if (cmd_valid && cmd_ready) begin
               acc_cnt++;
               acc_cyc  = cyc;
               burst_en = 0;
               if (exp_q.size() != 0) cur = exp_q[0];
            end
            if (busy && (die_period != RW'(DIE) || pulse_period != RW'(PW) ||
                         default_level != cur.lvl)) begin
               shadow_bad++;
            end
            if (pwm_en) begin
               if (burst_en == 0) chk("en_after_accept", cyc - acc_cyc, 1);
               else chk("en_after_pulse_valid", cyc - pv_cyc, cur.gap + 1);
               chk("pulses_done_at_fire", int'(pulses_done), burst_en);
               burst_en++;
               en_total++;
               en_cyc = cyc;
            end
            if (done || aborted) begin
               if (done) done_total++;
               if (aborted) begin
                  ab_total++;
                  ab_cyc = cyc;
               end
               if (exp_q.size() == 0) begin
                  chk("unexpected_end_strobe", exp_q.size(), 1);
               end else begin
                  cur = exp_q.pop_front();
                  chk("pulses_done", int'(pulses_done), cur.exp_pulses);
                  chk("en_count", burst_en, cur.exp_en);
                  chk("done_flag", int'(done), cur.exp_done);
                  chk("aborted_flag", int'(aborted), cur.exp_ab);
                  if (aborted) chk("dis_cycles_at_aborted", dis_run, 2);
                  if (done) chk("done_latency", cyc - ((cur.exp_pulses == 0) ? acc_cyc : pv_cyc), 1);
                  chk("shadow_stable", shadow_bad, 0);
               end
               shadow_bad = 0;
               end_seen   = 1'b1;
            end
         end
      end
   end

   task automatic send(input vec_t v);
      int n;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(posedge io_clk); #1;
         n++;
      end
      chk("ready_before_send", int'(cmd_ready), 1);
      exp_q.push_back(v);
      cmd_pulse_cnt     = CW'(v.cnt);
      cmd_gap           = RW'(v.gap);
      cmd_die_period    = RW'(DIE);
      cmd_pulse_period  = RW'(PW);
      cmd_default_level = v.lvl;
      end_seen          = 1'b0;
      cmd_valid         = 1'b1;
      @(posedge io_clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (!end_seen && n < 2000) begin
         @(posedge io_clk); #1;
         n++;
      end
      chk("burst_end_seen", int'(end_seen), 1);
   endtask

   task automatic step();
      @(posedge io_clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit: got no finish, expected finish before 500000 ns");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      vec_t v;
      int   n;
      int   d0;
      int   a0;
      vecs[0] = '{3, 0, 0, 3, 3, 1, 0, 1'b0};
      vecs[1] = '{2, 4, 0, 2, 2, 1, 0, 1'b1};
      vecs[2] = '{5, 1, 2, 1, 2, 0, 1, 1'b0};
      vecs[3] = '{0, 0, 0, 0, 0, 1, 0, 1'b1};
      vecs[4] = '{1, 7, 0, 1, 1, 1, 0, 1'b0};
      vecs[5] = '{4, 2, 0, 4, 4, 1, 0, 1'b1};

      #200;
      @(posedge io_clk); #1;
      io_rst_n = 1'b1;
      #1;
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pwm_en", int'(pwm_en), 0);
      chk("rst_pwm_dis", int'(pwm_dis), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_aborted", int'(aborted), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_pulses_done", int'(pulses_done), 0);
      chk("rst_die_period", int'(die_period), 0);
      chk("rst_pulse_period", int'(pulse_period), 0);
      chk("rst_default_level", int'(default_level), 0);
      repeat (10) step();
      chk("no_en_without_cmd", en_total, 0);

      for (int i = 0; i < 6; i++) begin
         send(vecs[i]);
         if (vecs[i].abort_at > 0) begin
            n = 0;
            while (burst_en < vecs[i].abort_at && n < 500) begin
               step();
               n++;
            end
            repeat (2) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
         end
         wait_end();
      end
      step();
      chk("idle_hold_die_period", int'(die_period), DIE);
      chk("idle_hold_pulse_period", int'(pulse_period), PW);
      chk("idle_hold_default_level", int'(default_level), 1);
      chk("idle_hold_pulses_done", int'(pulses_done), 4);

      // Abort cycle-exact sequence, then an immediate new command.
      v = '{5, 0, 0, 0, 1, 0, 1, 1'b0};
      send(v);
      repeat (2) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_c1_pwm_dis", int'(pwm_dis), 1);
      chk("abort_c1_aborted", int'(aborted), 0);
      chk("abort_c1_cmd_ready", int'(cmd_ready), 0);
      step();
      chk("abort_c2_pwm_dis", int'(pwm_dis), 1);
      chk("abort_c2_aborted", int'(aborted), 1);
      step();
      chk("abort_c3_cmd_ready", int'(cmd_ready), 1);
      chk("abort_c3_pwm_dis", int'(pwm_dis), 0);
      chk("abort_c3_pulses_done", int'(pulses_done), 0);
      v = '{1, 0, 0, 1, 1, 1, 0, 1'b1};
      send(v);
      chk("accept_after_abort", acc_cyc - ab_cyc, 1);
      wait_end();

      // Watchdog expiry with a silent generator.
      mute = 1'b1;
      v = '{2, 0, 0, 0, 1, 0, 1, 1'b0};
      send(v);
      wait_end();
      chk("watchdog_latency", dis_start_cyc - en_cyc, TO);
      chk("timeout_set", int'(timeout), 1);
      repeat (3) step();
      chk("timeout_sticky", int'(timeout), 1);
      mute = 1'b0;
      v = '{0, 0, 0, 0, 0, 1, 0, 1'b0};
      send(v);
      chk("timeout_cleared_on_accept", int'(timeout), 0);
      wait_end();

      // Abort in the same cycle as the final pulse_valid.
      v = '{1, 0, 0, 1, 1, 0, 1, 1'b0};
      send(v);
      n = 0;
      while (m_cnt != 1 && n < 100) begin
         step();
         n++;
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      wait_end();

      // cmd_valid held through a whole burst.
      step();
      a0 = acc_cnt;
      v = '{2, 0, 0, 2, 2, 1, 0, 1'b0};
      exp_q.push_back(v);
      cmd_pulse_cnt     = CW'(v.cnt);
      cmd_gap           = '0;
      cmd_default_level = v.lvl;
      end_seen          = 1'b0;
      cmd_valid         = 1'b1;
      n = 0;
      while (!end_seen && n < 500) begin
         step();
         n++;
      end
      cmd_valid = 1'b0;
      chk("held_valid_single_accept", acc_cnt - a0, 1);
      chk("ready_after_done", int'(cmd_ready), 1);
      step();

      // Reset while in GAP.
      v = '{3, 7, 0, 3, 3, 1, 0, 1'b1};
      send(v);
      n = 0;
      while (burst_en < 1 && n < 100) begin
         step();
         n++;
      end
      repeat (10) step();
      chk("gap_pulses_done", int'(pulses_done), 1);
      chk("gap_busy", int'(busy), 1);
      chk("gap_pwm_en", int'(pwm_en), 0);
      io_rst_n = 1'b0;
      #2;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_pulses_done", int'(pulses_done), 0);
      chk("midrst_die_period", int'(die_period), 0);
      chk("midrst_pulse_period", int'(pulse_period), 0);
      chk("midrst_default_level", int'(default_level), 0);
      chk("midrst_pwm_en", int'(pwm_en), 0);
      chk("midrst_done", int'(done), 0);
      exp_q.delete();
      d0 = done_total;
      a0 = ab_total;
      step();
      io_rst_n = 1'b1;
      repeat (12) step();
      chk("midrst_no_done", done_total - d0, 0);
      chk("midrst_no_aborted", ab_total - a0, 0);
      chk("midrst_cmd_ready", int'(cmd_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/half_pwm_burst_ctrl.md
# half_pwm_burst_ctrl

Burst sequencer for `half_pwm_die`. It accepts a burst command (pulse count, dead time, pulse period, inter-pulse gap, default level) over a valid/ready handshake and holds the configuration stable for the whole burst. It fires one-cycle start strobes into the half-bridge generator, counts `pulse_valid` completions, and reports done. A watchdog and an external abort force the generator off through `pwm_dis`.

## Interface
Parameters:
- `_RAM_WIDTH`, 32, width of the period and gap fields.
- `CNT_WIDTH`, 16, width of the pulse count.
- `TIMEOUT_CYCLES`, 65536, maximum cycles in WAIT_PULSE before a forced abort; must be ≥ 2.

Ports:
- `io_clk` in 1: single clock.
- `io_rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake; accepted on the cycle both are high.
- `cmd_pulse_cnt` in CNT_WIDTH: pulses in the burst.
- `cmd_die_period`, `cmd_pulse_period`, `cmd_gap` in _RAM_WIDTH: dead time, pulse width, idle cycles between pulses.
- `cmd_default_level` in 1: idle output level.
- `abort` in 1: terminate the current burst.
- `pwm_en` out 1: one-cycle start strobe to `half_pwm_die.io_en`.
- `pwm_dis` out 1: to `half_pwm_die.pwm_dis`.
- `die_period`, `pulse_period` out _RAM_WIDTH; `default_level` out 1: shadowed configuration.
- `pulse_valid` in 1: one-cycle completion pulse from `half_pwm_die`.
- `busy` out 1: high when not IDLE.
- `done` out 1, `aborted` out 1: one-cycle end-of-burst strobes.
- `timeout` out 1: sticky; set by a watchdog expiry, cleared on the next command acceptance.
- `pulses_done` out CNT_WIDTH: completed pulses in the current or last burst.

## Operation
- States: IDLE, FIRE, WAIT_PULSE, GAP, FINISH, ABORT.
- **Moore outputs:**
  - `cmd_ready` = IDLE.
  - `pwm_en` = FIRE.
  - `pwm_dis` = ABORT.
  - `done` = FINISH.
  - `busy` = not IDLE.
- **IDLE, on accept:**
  - Latch all `cmd_*` into shadow registers.
  - Clear `pulses_done` and `timeout`.
  - Go to FINISH if `cmd_pulse_cnt` = 0, else go to FIRE.
- **FIRE:** clear the watchdog; go to WAIT_PULSE.
- **WAIT_PULSE, on `pulse_valid`:**
  - Increment `pulses_done`.
  - If the new value equals the shadow count, go to FINISH.
  - Else if the shadow gap = 0, go to FIRE.
  - Else load the gap counter with gap−1 and go to GAP.
- **WAIT_PULSE, watchdog:** the watchdog increments every WAIT_PULSE cycle. When it reaches TIMEOUT_CYCLES−1 without `pulse_valid`, set `timeout` and go to ABORT.
- **GAP:** decrement; at 0 go to FIRE.
- **FINISH:** go to IDLE.
- **ABORT:** `pwm_dis` is held for 2 cycles. `aborted` pulses on the second ABORT cycle. Then go to IDLE.
- **`abort` input:**
  - In FIRE, WAIT_PULSE or GAP, `abort` forces ABORT on the next cycle.
  - Ignored in IDLE, FINISH and ABORT; a command offered in IDLE in the same cycle is accepted.
- **`abort` and `pulse_valid` in the same cycle:** the pulse is counted, then ABORT. Abort wins even if that pulse was the last one, so `done` does not fire.
- **Shadow outputs:** `die_period`, `pulse_period` and `default_level` change only on acceptance and hold through IDLE afterwards.
- **`pulses_done`:** saturates at all-ones; it is never expected to get there because it stops at the shadow count.
- **Reset (asynchronous, any state):**
  - State goes to IDLE.
  - All outputs are 0 except `cmd_ready`, which is 1 once reset is released.
  - Shadow registers and counters are cleared to 0.
  - No `done` or `aborted` strobe is issued for a burst interrupted by reset.

## Timing
- Accept at edge k → `pwm_en` high during cycle k+1.
- `pulse_valid` sampled at edge t:
  - gap = 0 → `pwm_en` in cycle t+1.
  - gap = G → GAP for G cycles, then `pwm_en` in cycle t+1+G.
- Last `pulse_valid` at edge t → `done` in cycle t+1 → `cmd_ready` in cycle t+2.
- `cnt` = 0: accept at k → `done` at k+1 → `cmd_ready` at k+2; no `pwm_en`.
- `abort` sampled at edge a → `pwm_dis` in cycles a+1 and a+2, `aborted` in cycle a+2, `cmd_ready` in cycle a+3.
- Watchdog: `pwm_en` in cycle f with no `pulse_valid` → `pwm_dis` starts at cycle f+TIMEOUT_CYCLES.

## Structure
- The package `half_pwm_pkg` holds:
  - the state encoding enum;
  - `ABORT_HOLD` = 2;
  - default widths shared with `half_pwm_die`.
- Sub-module `pwm_watchdog` (clear, enable, expire), parameterised by TIMEOUT_CYCLES.
- The FSM, shadow registers and gap counter stay in the top level.

## Test plan
Run tests 2–4 against a behavioural `half_pwm_die` model with die = 3 and pulse = 5.

1. Reset held 200 ns, then released → `cmd_ready` = 1 and every other output 0; `pwm_en` never rises with no command.
2. `cnt`=3, `die`=3, `pulse`=5, `gap`=0 → exactly 3 `pwm_en` strobes, each one cycle after the prior `pulse_valid`; `pulses_done`=3; `done` one cycle after the 3rd `pulse_valid`; `die_period`=3 and `pulse_period`=5 stable throughout.
3. `cnt`=2, `gap`=4 → second `pwm_en` exactly 5 cycles after the first `pulse_valid`.
4. `cnt`=5, `abort` in WAIT_PULSE of pulse 2 → `pwm_dis` for 2 cycles, `aborted` once, `pulses_done`=1, no `done`. A new command is accepted 3 cycles after abort.
5. `TIMEOUT_CYCLES`=16, model never returns `pulse_valid` → `pwm_dis` 16 cycles after `pwm_en`, `timeout`=1; `timeout` clears on the next acceptance.
6. `cnt`=0 → `done` the next cycle with no `pwm_en`. `cmd_valid` held during a burst is not accepted until `cmd_ready` returns. Asserting `io_rst_n` low mid-GAP → immediate IDLE with outputs zeroed.
